// File: rtl/sdrc_req_queue_pkg.sv
// Shared widths and helpers for the bank-controller request queue.
// Default ID/length widths mirror SDR_REQ_ID_W and REQ_BW from sdrc_define.v.
package sdrc_req_queue_pkg;

    localparam int unsigned SDR_REQ_ID_W = 4;
    localparam int unsigned SDR_REQ_BW   = 12;
    localparam int unsigned BA_W         = 2;
    localparam int unsigned ROW_W        = 12;
    localparam int unsigned COL_W        = 12;
    localparam int unsigned NUM_BANKS    = 4;
    localparam int unsigned FLAG_W       = 4;

    // Packed entry layout: id, start, last, wrap, write, ba, raddr, caddr, len
    function automatic int unsigned entry_width(input int unsigned id_w, input int unsigned len_w);
        return id_w + FLAG_W + BA_W + ROW_W + COL_W + len_w;
    endfunction

endpackage

// File: rtl/sdrc_open_row_tbl.sv
// Per-bank open-row table with combinational page-hit lookup.
// Precharge-all beats activate; activate beats a same-cycle single-bank precharge.
module sdrc_open_row_tbl
    import sdrc_req_queue_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             b_act_i,
    input  logic [BA_W-1:0]  b_act_ba_i,
    input  logic [ROW_W-1:0] b_act_row_i,
    input  logic             b_pre_i,
    input  logic [BA_W-1:0]  b_pre_ba_i,
    input  logic             b_pre_all_i,
    input  logic             lk_valid_i,
    input  logic [BA_W-1:0]  lk_ba_i,
    input  logic [ROW_W-1:0] lk_row_i,
    output logic             hit_o
);

    logic [NUM_BANKS-1:0] open_q;
    logic [NUM_BANKS-1:0] open_d;
    logic [ROW_W-1:0]     row_q [NUM_BANKS];

    always_comb begin
        open_d = open_q;
        if (b_pre_all_i) begin
            open_d = '0;
        end else begin
            if (b_pre_i) open_d[b_pre_ba_i] = 1'b0;
            if (b_act_i) open_d[b_act_ba_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) open_q <= '0;
        else       open_q <= open_d;
    end

    // Row contents only matter while the bank's open bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (b_act_i) row_q[b_act_ba_i] <= b_act_row_i;
    end

    assign hit_o = lk_valid_i & open_q[lk_ba_i] & (row_q[lk_ba_i] == lk_row_i);

endmodule

// File: rtl/sdrc_req_queue.sv
// Bank-side chunk receiver: acks r2b chunks into an in-order FIFO and presents
// the oldest entry, tagged with its page-hit status, to the bank state machines.
module sdrc_req_queue
    import sdrc_req_queue_pkg::*;
#(
    parameter int unsigned REQ_ID_W = SDR_REQ_ID_W,
    parameter int unsigned REQ_BW   = SDR_REQ_BW,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                r2b_req,
    input  logic [REQ_ID_W-1:0] r2b_req_id,
    input  logic                r2b_start,
    input  logic                r2b_last,
    input  logic                r2b_wrap,
    input  logic                r2b_write,
    input  logic [BA_W-1:0]     r2b_ba,
    input  logic [ROW_W-1:0]    r2b_raddr,
    input  logic [COL_W-1:0]    r2b_caddr,
    input  logic [REQ_BW-1:0]   r2b_len,
    output logic                b2r_ack,
    output logic                b2r_arb_ok,
    output logic                q_valid,
    input  logic                q_ready,
    output logic [REQ_ID_W-1:0] q_id,
    output logic                q_start,
    output logic                q_last,
    output logic                q_wrap,
    output logic                q_write,
    output logic [BA_W-1:0]     q_ba,
    output logic [ROW_W-1:0]    q_raddr,
    output logic [COL_W-1:0]    q_caddr,
    output logic [REQ_BW-1:0]   q_len,
    output logic                q_page_hit,
    input  logic                b_act,
    input  logic [BA_W-1:0]     b_act_ba,
    input  logic [ROW_W-1:0]    b_act_row,
    input  logic                b_pre,
    input  logic [BA_W-1:0]     b_pre_ba,
    input  logic                b_pre_all,
    output logic                q_idle
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = entry_width(REQ_ID_W, REQ_BW);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    // Ack uses the pre-pop count: a full FIFO never bypasses, even when popping.
    assign push       = r2b_req & ~reset & (cnt_q != CNT_W'(DEPTH));
    assign pop        = q_valid & q_ready;
    assign b2r_ack    = push;
    assign b2r_arb_ok = (cnt_q <= CNT_W'(DEPTH - 2));
    assign q_valid    = (cnt_q != '0);
    assign q_idle     = (cnt_q == '0) & ~r2b_req;

    assign wr_entry = {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
                       r2b_ba, r2b_raddr, r2b_caddr, r2b_len};
    assign head     = mem_q[rd_ptr_q];
    assign {q_id, q_start, q_last, q_wrap, q_write, q_ba, q_raddr, q_caddr, q_len} = head;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    sdrc_open_row_tbl u_open_row_tbl (
        .clk         (clk),
        .reset       (reset),
        .b_act_i     (b_act),
        .b_act_ba_i  (b_act_ba),
        .b_act_row_i (b_act_row),
        .b_pre_i     (b_pre),
        .b_pre_ba_i  (b_pre_ba),
        .b_pre_all_i (b_pre_all),
        .lk_valid_i  (q_valid),
        .lk_ba_i     (q_ba),
        .lk_row_i    (q_raddr),
        .hit_o       (q_page_hit)
    );

endmodule

// File: tb/tb_sdrc_req_queue.sv
// Randomized and directed bench for sdrc_req_queue against a queue-based
// reference model of the FIFO and a per-bank open/row page table.
module tb_sdrc_req_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  id;
        logic        start;
        logic        last;
        logic        wrap;
        logic        write;
        logic [1:0]  ba;
        logic [11:0] raddr;
        logic [11:0] caddr;
        logic [11:0] len;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        r2b_req;
    logic [3:0]  r2b_req_id;
    logic        r2b_start, r2b_last, r2b_wrap, r2b_write;
    logic [1:0]  r2b_ba;
    logic [11:0] r2b_raddr, r2b_caddr, r2b_len;
    logic        b2r_ack, b2r_arb_ok, q_valid, q_ready;
    logic [3:0]  q_id;
    logic        q_start, q_last, q_wrap, q_write;
    logic [1:0]  q_ba;
    logic [11:0] q_raddr, q_caddr, q_len;
    logic        q_page_hit;
    logic        b_act;
    logic [1:0]  b_act_ba;
    logic [11:0] b_act_row;
    logic        b_pre;
    logic [1:0]  b_pre_ba;
    logic        b_pre_all;
    logic        q_idle;

    int n_pass = 0;
    int n_tot  = 0;

    ent_t        mq[$];
    logic [3:0]  open_m;
    logic [11:0] row_m [4];

    always #5 clk = ~clk;

    sdrc_req_queue #(.REQ_ID_W(4), .REQ_BW(12), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .r2b_req(r2b_req), .r2b_req_id(r2b_req_id), .r2b_start(r2b_start),
        .r2b_last(r2b_last), .r2b_wrap(r2b_wrap), .r2b_write(r2b_write),
        .r2b_ba(r2b_ba), .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr), .r2b_len(r2b_len),
        .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok), .q_valid(q_valid), .q_ready(q_ready),
        .q_id(q_id), .q_start(q_start), .q_last(q_last), .q_wrap(q_wrap), .q_write(q_write),
        .q_ba(q_ba), .q_raddr(q_raddr), .q_caddr(q_caddr), .q_len(q_len),
        .q_page_hit(q_page_hit),
        .b_act(b_act), .b_act_ba(b_act_ba), .b_act_row(b_act_row),
        .b_pre(b_pre), .b_pre_ba(b_pre_ba), .b_pre_all(b_pre_all),
        .q_idle(q_idle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic set_idle();
        r2b_req = 1'b0; r2b_req_id = '0; r2b_start = 1'b0; r2b_last = 1'b0;
        r2b_wrap = 1'b0; r2b_write = 1'b0; r2b_ba = '0; r2b_raddr = '0;
        r2b_caddr = '0; r2b_len = '0;
        b_act = 1'b0; b_act_ba = '0; b_act_row = '0;
        b_pre = 1'b0; b_pre_ba = '0; b_pre_all = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] ba, input logic [11:0] ra, input logic [11:0] ca,
                           input logic [11:0] len, input logic st, input logic la);
        r2b_req    = 1'b1;
        r2b_req_id = 4'($urandom);
        r2b_wrap   = 1'($urandom);
        r2b_write  = 1'($urandom);
        r2b_start  = st;
        r2b_last   = la;
        r2b_ba     = ba;
        r2b_raddr  = ra;
        r2b_caddr  = ca;
        r2b_len    = len;
    endtask

    // Called just after a falling edge: checks outputs, crosses one rising edge,
    // advances the model, and returns on the next falling edge.
    task automatic step();
        logic ea;
        logic hit_e;
        ent_t e;
        #1;
        ea = r2b_req && !reset && (mq.size() != DEPTH);
        chk("ack", b2r_ack, ea);
        chk("arb_ok", b2r_arb_ok, (DEPTH - mq.size()) >= 2);
        chk("q_valid", q_valid, mq.size() != 0);
        chk("q_idle", q_idle, (mq.size() == 0) && !r2b_req);
        if (mq.size() != 0) begin
            chk("head", {q_id, q_start, q_last, q_wrap, q_write, q_ba, q_raddr, q_caddr, q_len}, mq[0]);
            hit_e = open_m[mq[0].ba] && (row_m[mq[0].ba] == mq[0].raddr);
            chk("page_hit", q_page_hit, hit_e);
        end else begin
            chk("page_hit", q_page_hit, 1'b0);
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
            open_m = '0;
        end else begin
            if (mq.size() != 0 && q_ready) void'(mq.pop_front());
            if (ea) begin
                e = '{r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
                      r2b_ba, r2b_raddr, r2b_caddr, r2b_len};
                mq.push_back(e);
            end
            if (b_pre_all) begin
                open_m = '0;
            end else begin
                if (b_pre) open_m[b_pre_ba] = 1'b0;
                if (b_act) open_m[b_act_ba] = 1'b1;
            end
            if (b_act) row_m[b_act_ba] = b_act_row;
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        q_ready = 1'b0;
        reset   = 1'b1;
        open_m  = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        step();
        reset = 1'b0;
        #1;
        chk("rst_valid", q_valid, 1'b0);
        chk("rst_arb_ok", b2r_arb_ok, 1'b1);
        chk("rst_idle", q_idle, 1'b1);
        chk("rst_hit", q_page_hit, 1'b0);
        chk("rst_ack", b2r_ack, 1'b0);

        // Single push, head visible next cycle
        set_req(2'd1, 12'h123, 12'h0F8, 12'd8, 1'b1, 1'b1);
        #1 chk("push1_ack", b2r_ack, 1'b1);
        step();
        set_idle();
        #1;
        chk("push1_valid", q_valid, 1'b1);
        chk("push1_raddr", q_raddr, 12'h123);
        chk("push1_caddr", q_caddr, 12'h0F8);
        chk("push1_len", q_len, 12'd8);
        chk("push1_hit", q_page_hit, 1'b0);

        // Fill with q_ready low
        set_req(2'd0, 12'h001, 12'h010, 12'd4, 1'b1, 1'b1); step();
        #1 chk("cnt2_arb_ok", b2r_arb_ok, 1'b1);
        set_req(2'd0, 12'h002, 12'h020, 12'd4, 1'b1, 1'b1); step();
        #1 chk("cnt3_arb_ok", b2r_arb_ok, 1'b0);
        set_req(2'd3, 12'h003, 12'h030, 12'd4, 1'b1, 1'b1); step();
        set_req(2'd3, 12'h004, 12'h040, 12'd4, 1'b1, 1'b1);
        #1 chk("full_ack", b2r_ack, 1'b0);
        step();
        q_ready = 1'b1;
        #1 chk("full_pop_ack", b2r_ack, 1'b0);
        step();
        q_ready = 1'b0;
        #1 chk("after_pop_ack", b2r_ack, 1'b1);
        step();

        // Drain to 2, then page-split pair back to back
        set_idle();
        q_ready = 1'b1;
        step(); step();
        q_ready = 1'b0;
        set_req(2'd1, 12'h200, 12'h3F8, 12'd8, 1'b1, 1'b0);
        #1 chk("split1_ack", b2r_ack, 1'b1);
        step();
        set_req(2'd2, 12'h200, 12'h000, 12'd4, 1'b0, 1'b1);
        #1 chk("split2_ack", b2r_ack, 1'b1);
        step();

        // Drain to 2, then simultaneous push/pop
        set_idle();
        q_ready = 1'b1;
        step(); step();
        set_req(2'd0, 12'h777, 12'h008, 12'd2, 1'b1, 1'b1);
        step();
        set_idle();
        q_ready = 1'b0;
        #1 chk("pushpop_arb_ok", b2r_arb_ok, 1'b1);
        q_ready = 1'b1;
        repeat (3) step();
        q_ready = 1'b0;

        // Page table behaviour
        reset = 1'b1; step(); reset = 1'b0;
        set_req(2'd2, 12'h055, 12'h000, 12'd1, 1'b1, 1'b1); step();
        set_idle();
        b_act = 1'b1; b_act_ba = 2'd2; b_act_row = 12'h055; step();
        set_idle();
        #1 chk("act_hit", q_page_hit, 1'b1);
        b_pre_all = 1'b1; b_act = 1'b1; b_act_ba = 2'd2; b_act_row = 12'h055; step();
        set_idle();
        #1 chk("preall_hit", q_page_hit, 1'b0);
        b_act = 1'b1; b_act_ba = 2'd2; b_act_row = 12'h055;
        b_pre = 1'b1; b_pre_ba = 2'd2; step();
        set_idle();
        #1 chk("act_pre_hit", q_page_hit, 1'b1);

        // Reset with entries queued
        set_req(2'd0, 12'h010, 12'h000, 12'd1, 1'b1, 1'b1); step();
        set_req(2'd1, 12'h011, 12'h000, 12'd1, 1'b1, 1'b1); step();
        reset = 1'b1;
        #1 chk("rst_req_ack", b2r_ack, 1'b0);
        step();
        reset = 1'b0;
        set_idle();
        #1;
        chk("rst3_valid", q_valid, 1'b0);
        chk("rst3_arb_ok", b2r_arb_ok, 1'b1);
        chk("rst3_idle", q_idle, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            q_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0)
                set_req(2'($urandom), $urandom_range(0, 1) ? 12'h010 : 12'h011,
                        12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom));
            else
                r2b_req = 1'b0;
            b_act     = ($urandom_range(0, 3) == 0);
            b_act_ba  = 2'($urandom);
            b_act_row = $urandom_range(0, 1) ? 12'h010 : 12'h011;
            b_pre     = ($urandom_range(0, 3) == 0);
            b_pre_ba  = 2'($urandom);
            b_pre_all = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
